// File: rtl/sc_regarb_pkg.sv
// Shared types and helpers for the register-bank write arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sc_regarb_pkg;

  // Sequencer states: one write occupies IDLE -> WRITE -> ACK.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a single requester still gets a 1-bit index.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_regarb_rr_picker.sv
// Round-robin picker: first set req bit at or above ptr, wrapping to 0.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to consume the grant.
module sc_regarb_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDXW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDXW-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDXW-1:0]    idx,
  output logic               any_req
);

  // Walk the requesters starting at the pointer; the first hit wins.
  always_comb begin
    int cand;
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    cand    = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/sc_regbank_arbiter.sv
// Round-robin write sequencer sharing one register bank among NUM_REQ requesters.
// Latency: 3 cycles per write (IDLE sample, WRITE strobe, ACK pulse); 1 write per 3 cycles.
// Backpressure: requests are level; a requester holds req until its ack, then drops it.
module sc_regbank_arbiter
  import sc_regarb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_REGS  = 8,
  parameter int ADDRWIDTH = 3,
  parameter int DATAWIDTH = 32
) (
  input  logic                           SC_REGARB_CLOCK_50,
  input  logic                           SC_REGARB_RESET_InLow,
  input  logic [NUM_REQ-1:0]             SC_REGARB_req_InBus,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   SC_REGARB_addr_InBus,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   SC_REGARB_data_InBus,
  output logic [NUM_REQ-1:0]             SC_REGARB_ack_OutBus,
  output logic                           SC_REGARB_err_Out,
  output logic                           SC_REGARB_busy_Out,
  output logic [NUM_REGS-1:0]            SC_REGARB_load_OutBus,
  output logic [DATAWIDTH-1:0]           SC_REGARB_data_OutBus
);

  localparam int IDXW = clog2(NUM_REQ);

  state_t                state_q, state_d;
  logic [IDXW-1:0]       ptr_q, ptr_d;
  logic [IDXW-1:0]       win_q, win_d;
  logic [ADDRWIDTH-1:0]  addr_q, addr_d;
  logic [NUM_REGS-1:0]   load_q, load_d;
  logic [DATAWIDTH-1:0]  dout_q, dout_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDXW-1:0]       pick_idx;
  logic                  pick_any;
  logic [ADDRWIDTH-1:0]  addr_sel;
  logic [DATAWIDTH-1:0]  data_sel;

  sc_regarb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_picker (
    .req     (SC_REGARB_req_InBus),
    .ptr     (ptr_q),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  // AND-OR mux of the granted requester's address and data (grant is one-hot or zero).
  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_grant[i]) begin
        addr_sel = addr_sel | SC_REGARB_addr_InBus[i*ADDRWIDTH +: ADDRWIDTH];
        data_sel = data_sel | SC_REGARB_data_InBus[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead so they can be registered.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    load_d  = '1;
    dout_d  = dout_q;
    ack_d   = '0;
    err_d   = 1'b0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = WRITE;
          win_d   = pick_idx;
          addr_d  = addr_sel;
          dout_d  = data_sel;
          busy_d  = 1'b1;
          // An out-of-range address matches no bit, so the strobe stays all ones.
          for (int k = 0; k < NUM_REGS; k++) begin
            load_d[k] = (int'(addr_sel) != k);
          end
        end else begin
          dout_d = '0;
        end
      end
      WRITE: begin
        state_d      = ACK;
        busy_d       = 1'b1;
        ack_d[win_q] = 1'b1;
        err_d        = (int'(addr_q) >= NUM_REGS);
        ptr_d        = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
      end
      ACK: begin
        // Data bus was held through ACK; it returns to idle value with the bank quiet.
        state_d = IDLE;
        dout_d  = '0;
      end
      default: begin
        state_d = IDLE;
        dout_d  = '0;
      end
    endcase
  end

  // State, latched request and registered outputs; async reset aborts any write in flight.
  always_ff @(posedge SC_REGARB_CLOCK_50 or negedge SC_REGARB_RESET_InLow) begin
    if (!SC_REGARB_RESET_InLow) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      load_q  <= '1;
      dout_q  <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign SC_REGARB_ack_OutBus  = ack_q;
  assign SC_REGARB_err_Out     = err_q;
  assign SC_REGARB_busy_Out    = busy_q;
  assign SC_REGARB_load_OutBus = load_q;
  assign SC_REGARB_data_OutBus = dout_q;

endmodule

// File: tb/tb_sc_regbank_arbiter.sv
// Directed bench for the register-bank write arbiter with a behavioural register bank.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: requesters drop req during ACK, as the handshake expects.
module tb_sc_regbank_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [3:0]   req5;
  logic [11:0]  abus;
  logic [127:0] dbus;
  logic [3:0]   ack, ack5;
  logic         err, err5, busy, busy5;
  logic [7:0]   load;
  logic [4:0]   load5;
  logic [31:0]  dout, dout5;
  logic [31:0]  bank [8];

  int tests  = 0;
  int failed = 0;

  sc_regbank_arbiter #(.NUM_REQ(4), .NUM_REGS(8), .ADDRWIDTH(3), .DATAWIDTH(32)) u_dut (
    .SC_REGARB_CLOCK_50   (clk),
    .SC_REGARB_RESET_InLow(rst_n),
    .SC_REGARB_req_InBus  (req),
    .SC_REGARB_addr_InBus (abus),
    .SC_REGARB_data_InBus (dbus),
    .SC_REGARB_ack_OutBus (ack),
    .SC_REGARB_err_Out    (err),
    .SC_REGARB_busy_Out   (busy),
    .SC_REGARB_load_OutBus(load),
    .SC_REGARB_data_OutBus(dout)
  );

  sc_regbank_arbiter #(.NUM_REQ(4), .NUM_REGS(5), .ADDRWIDTH(3), .DATAWIDTH(32)) u_dut5 (
    .SC_REGARB_CLOCK_50   (clk),
    .SC_REGARB_RESET_InLow(rst_n),
    .SC_REGARB_req_InBus  (req5),
    .SC_REGARB_addr_InBus (abus),
    .SC_REGARB_data_InBus (dbus),
    .SC_REGARB_ack_OutBus (ack5),
    .SC_REGARB_err_Out    (err5),
    .SC_REGARB_busy_Out   (busy5),
    .SC_REGARB_load_OutBus(load5),
    .SC_REGARB_data_OutBus(dout5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural bank: register k captures the data bus on any edge where its strobe is low.
  initial for (int k = 0; k < 8; k++) bank[k] = '0;
  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) if (!load[k]) bank[k] <= dout;
  end

  typedef struct {
    logic [3:0]   req;
    logic [11:0]  abus;
    logic [127:0] dbus;
    logic [7:0]   load;
    logic [3:0]   ack;
    logic         err;
    logic         busy;
    logic [31:0]  dout;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hA0A0_0001;
  localparam logic [31:0] D2 = 32'hA0A0_0002;
  localparam logic [31:0] D3 = 32'hA0A0_0003;
  localparam logic [11:0]  ABUS_STD = {3'd7, 3'd6, 3'd5, 3'd4};
  localparam logic [11:0]  ABUS_T2  = {3'd7, 3'd6, 3'd5, 3'd3};
  localparam logic [11:0]  ABUS_T6  = {3'd7, 3'd6, 3'd5, 3'd2};
  localparam logic [127:0] DBUS_STD = {D3, D2, D1, D0};
  localparam logic [127:0] DBUS_T2  = {D3, D2, D1, 32'hDEADBEEF};
  localparam logic [127:0] DBUS_T6  = {D3, D2, D1, 32'h1234_5678};

  task automatic add(input logic [3:0] r, input logic [11:0] a, input logic [127:0] d,
                     input logic [7:0] l, input logic [3:0] k, input logic e,
                     input logic b, input logic [31:0] o);
    vec_t v;
    v.req = r; v.abus = a; v.dbus = d; v.load = l;
    v.ack = k; v.err = e; v.busy = b; v.dout = o;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Rows: inputs applied during a cycle, outputs expected after the following edge.
    // Requesters 0..3 all held, each dropping after its ack: served 0,1,2,3.
    add(4'b1111, ABUS_STD, DBUS_STD, 8'hEF, 4'b0000, 0, 1, D0);
    add(4'b1111, ABUS_STD, DBUS_STD, 8'hFF, 4'b0001, 0, 1, D0);
    add(4'b1110, ABUS_STD, DBUS_STD, 8'hFF, 4'b0000, 0, 0, 32'h0);
    add(4'b1110, ABUS_STD, DBUS_STD, 8'hDF, 4'b0000, 0, 1, D1);
    add(4'b1110, ABUS_STD, DBUS_STD, 8'hFF, 4'b0010, 0, 1, D1);
    add(4'b1100, ABUS_STD, DBUS_STD, 8'hFF, 4'b0000, 0, 0, 32'h0);
    add(4'b1100, ABUS_STD, DBUS_STD, 8'hBF, 4'b0000, 0, 1, D2);
    add(4'b1100, ABUS_STD, DBUS_STD, 8'hFF, 4'b0100, 0, 1, D2);
    add(4'b1000, ABUS_STD, DBUS_STD, 8'hFF, 4'b0000, 0, 0, 32'h0);
    add(4'b1000, ABUS_STD, DBUS_STD, 8'h7F, 4'b0000, 0, 1, D3);
    add(4'b1000, ABUS_STD, DBUS_STD, 8'hFF, 4'b1000, 0, 1, D3);
    add(4'b0000, ABUS_STD, DBUS_STD, 8'hFF, 4'b0000, 0, 0, 32'h0);
    // Serve requester 2 alone so the pointer lands on 3, then 4'b1010: 3 before 1.
    add(4'b0100, ABUS_STD, DBUS_STD, 8'hBF, 4'b0000, 0, 1, D2);
    add(4'b0100, ABUS_STD, DBUS_STD, 8'hFF, 4'b0100, 0, 1, D2);
    add(4'b0000, ABUS_STD, DBUS_STD, 8'hFF, 4'b0000, 0, 0, 32'h0);
    add(4'b1010, ABUS_STD, DBUS_STD, 8'h7F, 4'b0000, 0, 1, D3);
    add(4'b1010, ABUS_STD, DBUS_STD, 8'hFF, 4'b1000, 0, 1, D3);
    add(4'b0010, ABUS_STD, DBUS_STD, 8'hFF, 4'b0000, 0, 0, 32'h0);
    add(4'b0010, ABUS_STD, DBUS_STD, 8'hDF, 4'b0000, 0, 1, D1);
    add(4'b0010, ABUS_STD, DBUS_STD, 8'hFF, 4'b0010, 0, 1, D1);
    add(4'b0000, ABUS_STD, DBUS_STD, 8'hFF, 4'b0000, 0, 0, 32'h0);
    // Requester 0 writes 0xDEADBEEF to register 3 (pointer at 2, wraps to 0).
    add(4'b0001, ABUS_T2, DBUS_T2, 8'hF7, 4'b0000, 0, 1, 32'hDEADBEEF);
    add(4'b0001, ABUS_T2, DBUS_T2, 8'hFF, 4'b0001, 0, 1, 32'hDEADBEEF);
    add(4'b0000, ABUS_T2, DBUS_T2, 8'hFF, 4'b0000, 0, 0, 32'h0);
    add(4'b0000, ABUS_T2, DBUS_T2, 8'hFF, 4'b0000, 0, 0, 32'h0);

    // Reset held 3 cycles with no requests.
    rst_n = 1'b0; req = '0; req5 = '0; abus = ABUS_STD; dbus = DBUS_STD;
    repeat (3) step();
    check("rst load", 64'(load), 64'hFF);
    check("rst ack", 64'(ack), 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    check("rst err", 64'(err), 64'h0);
    check("rst dout", 64'(dout), 64'h0);
    rst_n = 1'b1;
    repeat (2) step();
    check("idle load", 64'(load), 64'hFF);
    check("idle ack", 64'(ack), 64'h0);
    check("idle busy", 64'(busy), 64'h0);

    // Table-driven cycles.
    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req; abus = tbl[i].abus; dbus = tbl[i].dbus;
      step();
      check($sformatf("row%0d load", i), 64'(load), 64'(tbl[i].load));
      check($sformatf("row%0d ack", i),  64'(ack),  64'(tbl[i].ack));
      check($sformatf("row%0d err", i),  64'(err),  64'(tbl[i].err));
      check($sformatf("row%0d busy", i), 64'(busy), 64'(tbl[i].busy));
      check($sformatf("row%0d dout", i), 64'(dout), 64'(tbl[i].dout));
    end
    check("bank3", 64'(bank[3]), 64'h0000_0000_DEAD_BEEF);
    check("bank4", 64'(bank[4]), 64'(D0));
    check("bank5", 64'(bank[5]), 64'(D1));
    check("bank6", 64'(bank[6]), 64'(D2));
    check("bank7", 64'(bank[7]), 64'(D3));

    // Reset pulsed in the middle of a WRITE to register 2.
    req = 4'b0001; abus = ABUS_T6; dbus = DBUS_T6;
    step();
    check("abort write load", 64'(load), 64'hFB);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort async load", 64'(load), 64'hFF);
    check("abort async busy", 64'(busy), 64'h0);
    check("abort async dout", 64'(dout), 64'h0);
    req = 4'b0000;
    step();
    check("abort ack in reset", 64'(ack), 64'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("abort ack c%0d", c), 64'(ack), 64'h0);
      check($sformatf("abort busy c%0d", c), 64'(busy), 64'h0);
    end
    check("abort bank2", 64'(bank[2]), 64'h0);

    // Five-register bank: requester 1 targets address 5, which does not exist.
    req5 = 4'b0010; abus = ABUS_STD; dbus = DBUS_STD;
    step();
    check("bad addr load", 64'(load5), 64'h1F);
    check("bad addr busy", 64'(busy5), 64'h1);
    step();
    check("bad addr ack", 64'(ack5), 64'h2);
    check("bad addr err", 64'(err5), 64'h1);
    check("bad addr load ack", 64'(load5), 64'h1F);
    req5 = 4'b0000;
    step();
    check("bad addr ack clr", 64'(ack5), 64'h0);
    check("bad addr err clr", 64'(err5), 64'h0);
    check("bad addr busy clr", 64'(busy5), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
